// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path constants and types used by the instruction fetch queue.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous ring-buffer FIFO with flush; flush beats push, pop and push may coincide.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= r_rd_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));

endmodule

// File: rtl/inst_fetch_queue.sv
// RV32I fetch front end: sequential PC generation, credit-limited in-order memory
// requests, a response queue feeding decode, and redirect with drain of stale responses.
module inst_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = rv32i_pkg::XLEN,
    parameter int              ILEN     = rv32i_pkg::ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    fq_state_e          r_state;
    fq_state_e          w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      w_out_nxt;
    logic [ILEN-1:0]    r_hold_inst;
    logic [XLEN-1:0]    r_hold_pc;

    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic [XLEN+ILEN-1:0] w_head;
    logic [CW:0]        w_inflight;
    logic               w_req_fire;
    logic               w_rsp_keep;
    logic               w_pop;
    logic [XLEN-1:0]    w_target;

    // Same-cycle pops are deliberately not credited: occupancy counts the entry being taken.
    assign w_inflight     = (CW+1)'(w_count) + (CW+1)'(r_outstanding);
    assign imem_req_valid = !rst && (r_state == FQ_RUN) && !redirect_valid && !w_full
                            && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_keep     = imem_rsp_valid && (r_state == FQ_RUN) && !redirect_valid;
    assign w_pop          = !w_empty && inst_ready;
    assign w_target       = redirect_pc & ALIGN_MASK;

    sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_keep),
        .i_data  ({r_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Outstanding request count: issue adds, any response (kept or dropped) removes.
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_fire && !imem_rsp_valid) begin
            w_out_nxt = r_outstanding + CW'(1);
        end else if (!w_req_fire && imem_rsp_valid && (r_outstanding != CW'(0))) begin
            w_out_nxt = r_outstanding - CW'(1);
        end else begin
            w_out_nxt = r_outstanding;
        end
    end

    // Next fetch state; redirect wins over everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_out_nxt != CW'(0)) ? FQ_DRAIN : FQ_RUN;
        end else begin
            case (r_state)
                FQ_RUN:   w_state_nxt = FQ_RUN;
                FQ_DRAIN: w_state_nxt = (w_out_nxt == CW'(0)) ? FQ_RUN : FQ_DRAIN;
                default:  w_state_nxt = FQ_RUN;
            endcase
        end
    end

    // State and outstanding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FQ_RUN;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
        end
    end

    // Request PC and response PC tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc     <= w_target;
            r_rsp_pc <= w_target;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + STEP;
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + STEP;
            end
        end
    end

    // Remember the last visible head so decode outputs hold while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_pc   <= '0;
            r_hold_inst <= '0;
        end else if (!w_empty) begin
            r_hold_pc   <= w_head[XLEN+ILEN-1:ILEN];
            r_hold_inst <= w_head[ILEN-1:0];
        end
    end

    assign inst_valid = !w_empty;
    assign inst_pc    = w_empty ? r_hold_pc   : w_head[XLEN+ILEN-1:ILEN];
    assign inst       = w_empty ? r_hold_inst : w_head[ILEN-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a memory model with random latency, a request-level
// reference model with epochs for redirects, and a decoupled decode-side monitor.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          total = 0, bad = 0, cyc = 0, epoch = 0;
    int          n_fire = 0, n_pops = 0, last_fire_cyc = -1, mem_lat = 1;
    int          base, fired_pre, pops_pre;
    logic [31:0] model_pc;
    logic [31:0] last_fire_addr = 32'hFFFF_FFFF;
    logic        force_dead = 1'b0, saw_dead = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive at negedge, check requests at +1, update the model at +3.
    task automatic do_cycle(input logic rd_v, input logic [31:0] rd_pc, input logic i_rdy, input logic m_rdy);
        logic        rsp_now, fire, exp_req;
        int          stale, due;
        mreq_t       r;
        logic [31:0] d;
        @(negedge clk);
        redirect_valid = rd_v;
        redirect_pc    = rd_pc;
        inst_ready     = i_rdy;
        imem_req_ready = m_rdy;
        rsp_now        = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_q[0].data : $urandom;
        #1;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_req = !rd_v && (stale == 0) && ((exp_q.size() + mem_q.size()) < DEPTH);
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        fire = imem_req_valid && m_rdy;
        if (fire) chk("req_addr", imem_req_addr, model_pc);
        #2;
        if (rsp_now) begin
            r = mem_q.pop_front();
            if (!rd_v && (r.epoch == epoch)) exp_q.push_back('{r.addr, r.data});
        end
        if (fire) begin
            due = cyc + mem_lat;
            if ((mem_q.size() != 0) && (mem_q[$].due >= due)) due = mem_q[$].due + 1;
            d = force_dead ? 32'hDEAD_BEEF : $urandom;
            force_dead = 1'b0;
            mem_q.push_back('{model_pc, d, epoch, due});
            n_fire++;
            last_fire_addr = imem_req_addr;
            last_fire_cyc  = cyc;
        end
        if (rd_v) begin
            epoch++;
            exp_q.delete();
            model_pc = rd_pc & 32'hFFFF_FFFC;
        end else if (fire) begin
            model_pc = model_pc + 32'd4;
        end
        cyc++;
    endtask

    // Assert reset between clock edges, check outputs immediately, then release at a negedge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        mem_q.delete();
        exp_q.delete();
        epoch++;
        model_pc = RESET_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Decode-side monitor: pops the scoreboard whenever the DUT hands over an instruction.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        #2;
        if (!rst) begin
            exp_v = (exp_q.size() != 0);
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_v});
            if (inst_valid && inst_ready) begin
                if (exp_v) begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst", inst, e.data);
                end
                if (inst == 32'hDEAD_BEEF) saw_dead = 1'b1;
                n_pops++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        model_pc = RESET_PC;

        // Streaming with 1-cycle memory and no backpressure.
        do_reset();
        mem_lat = 1;
        repeat (2) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        base = n_pops;
        repeat (10) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("throughput", n_pops - base, 32'd10);

        // Decode stalled: credit limits to DEPTH, a pop is credited one cycle later.
        do_reset();
        base = n_fire;
        repeat (8) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("bp_fires", n_fire - base, 32'd4);
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("bp_no_credit", n_fire - base, 32'd4);
        repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("bp_refill", n_fire - base, 32'd5);
        chk("bp_refill_addr", last_fire_addr, 32'h10);

        // Redirect with two requests in flight: drain, then resume at the target.
        do_reset();
        mem_lat = 6;
        base = cyc;
        repeat (2) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        do_cycle(1'b1, 32'h100, 1'b1, 1'b1);
        fired_pre = n_fire;
        pops_pre  = n_pops;
        for (int k = 0; k < 20 && n_fire == fired_pre; k++) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("drain_addr", last_fire_addr, 32'h100);
        chk("drain_resume_cycle", last_fire_cyc - base, 32'd8);
        chk("drain_no_inst", n_pops - pops_pre, 32'd0);

        // Misaligned redirect target with nothing outstanding.
        do_reset();
        mem_lat = 1;
        do_cycle(1'b1, 32'h103, 1'b1, 1'b1);
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("align_addr", last_fire_addr, 32'h100);
        chk("align_when", last_fire_cyc, cyc - 1);
        repeat (3) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Response, pop and redirect in the same cycle: the response must vanish.
        force_dead = 1'b1;
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        pops_pre = n_pops;
        do_cycle(1'b1, 32'h200, 1'b1, 1'b1);
        chk("same_cycle_pop", n_pops - pops_pre, 32'd1);
        do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("same_cycle_next_addr", last_fire_addr, 32'h200);
        chk("same_cycle_next_when", last_fire_cyc, cyc - 1);

        // Reset in the middle of a burst, then PC wrap-around.
        repeat (4) do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        do_reset();
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("post_rst_addr", last_fire_addr, RESET_PC);
        chk("post_rst_when", last_fire_cyc, cyc - 1);
        do_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("wrap_top", last_fire_addr, 32'hFFFF_FFFC);
        do_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("wrap_zero", last_fire_addr, 32'h0);
        chk("wrap_when", last_fire_cyc, cyc - 1);

        // Random traffic: latency, backpressure on both sides, and redirects.
        for (int k = 0; k < 3000; k++) begin
            mem_lat = $urandom_range(1, 4);
            do_cycle($urandom_range(0, 15) == 0, $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        chk("no_flushed_word", {31'd0, saw_dead}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
